// File: rtl/sort_result_streamer.sv
// Captures the sorter's parallel result words on sort_done, then streams them out
// one per transfer over valid/ready while checking that the stream never decreases.
module sort_result_streamer #(
    parameter  int N  = 10,
    parameter  int W  = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           sort_done,
    input  logic [N*W-1:0] dat_in,
    output logic           rd_en,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_index,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic           order_err,
    output logic           fin
);

    localparam logic [IW-1:0] LAST_INDEX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FIN
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   index_reg, index_next;
    logic            armed_reg, armed_next;
    logic [W-1:0]    prev_reg, prev_next;
    logic            order_err_reg, order_err_next;
    logic            fin_reg, fin_next;
    logic            rd_en_reg, rd_en_next;
    logic            capture;
    logic [W-1:0]    buffer_reg [N];
    logic [W-1:0]    cur_word;

    assign cur_word = buffer_reg[index_reg];

    // Buffer holds data only; it needs no reset and is written on the capture edge alone.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_buffer
            always_ff @(posedge clk) begin
                if (capture) begin
                    buffer_reg[gi] <= dat_in[gi*W +: W];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            index_reg     <= '0;
            armed_reg     <= 1'b1;
            prev_reg      <= '0;
            order_err_reg <= 1'b0;
            fin_reg       <= 1'b0;
            rd_en_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            armed_reg     <= armed_next;
            prev_reg      <= prev_next;
            order_err_reg <= order_err_next;
            fin_reg       <= fin_next;
            rd_en_reg     <= rd_en_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        armed_next     = armed_reg;
        prev_next      = prev_reg;
        order_err_next = order_err_reg;
        fin_next       = fin_reg;
        rd_en_next     = 1'b0;
        capture        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!sort_done) begin
                    armed_next = 1'b1;
                end else if (armed_reg) begin
                    capture        = 1'b1;
                    index_next     = '0;
                    order_err_next = 1'b0;
                    armed_next     = 1'b0;
                    rd_en_next     = 1'b1;
                    state_next     = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (index_reg != '0 && cur_word < prev_reg) begin
                        order_err_next = 1'b1;
                    end
                    prev_next = cur_word;
                    // Index saturates at the last word; leaving STREAM ends the set.
                    if (index_reg == LAST_INDEX) begin
                        fin_next   = 1'b1;
                        state_next = S_FIN;
                    end else begin
                        index_next = index_reg + IW'(1);
                    end
                end
            end
            S_FIN: begin
                if (!sort_done) begin
                    armed_next = 1'b1;
                    fin_next   = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Stream outputs derive from the async-reset state so they clear the moment reset asserts.
    assign out_valid = (state_reg == S_STREAM);
    assign out_data  = out_valid ? cur_word : '0;
    assign out_index = out_valid ? index_reg : '0;
    assign out_last  = out_valid && (index_reg == LAST_INDEX);
    assign rd_en     = rd_en_reg;
    assign order_err = order_err_reg;
    assign fin       = fin_reg;

endmodule
